wd_bus_master: RTL and testbench



---
 rtl/wd_bus_master.sv | 196 +++++++++++++++++++
 tb/tb_wd_bus_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wd_bus_master.sv
// wd_bus_master: bus-side initiator that writes the watchdog's registers.
// Emits two-beat (key, addr/data) writes plus a gap cycle on ABUS/DBUS.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   START           one-cycle pulse, starts config+init+service (IDLE only)
//   STOP            level, ends the sequence at the next WAIT/gap cycle
//   CFG[2:0]        config word {RST_LMT, SWLEN, FWLEN}, latched at START
//   SRV_PERIOD      WAIT cycles between service writes, latched at START
//   WDFAIL          watchdog failure flag, forces FAILED until RST
//   RSTOUT          watchdog reset output, observed only
//   ABUS[1:0]       watchdog address bus (registered)
//   DBUS[15:0]      watchdog data bus (registered)
//   BUSY            high outside IDLE and FAILED
//   FAIL_SEEN       sticky WDFAIL indication, cleared by RST only
//   SRV_CNT[7:0]    completed service writes, wraps 255->0
module wd_bus_master #(
    parameter logic [15:0] KEY       = 16'hA5C3,
    parameter logic [15:0] IDLE_WORD = 16'h0000,
    parameter int unsigned PER_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [2:0]       CFG,
    input  logic [PER_W-1:0] SRV_PERIOD,
    input  logic             WDFAIL,
    input  logic             RSTOUT,
    output logic [1:0]       ABUS,
    output logic [15:0]      DBUS,
    output logic             BUSY,
    output logic             FAIL_SEEN,
    output logic [7:0]       SRV_CNT
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CFG_K  = 4'd1,
        S_CFG_D  = 4'd2,
        S_CFG_G  = 4'd3,
        S_INIT_K = 4'd4,
        S_INIT_D = 4'd5,
        S_INIT_G = 4'd6,
        S_WAIT   = 4'd7,
        S_SRV_K  = 4'd8,
        S_SRV_D  = 4'd9,
        S_SRV_G  = 4'd10,
        S_FAILED = 4'd11
    } state_t;

    localparam logic [1:0]       ADDR_CFG  = 2'b00;
    localparam logic [1:0]       ADDR_SRV  = 2'b01;
    localparam logic [1:0]       ADDR_INIT = 2'b11;
    localparam logic [15:0]      DATA_ONE  = 16'h0001;
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       cfg_q, cfg_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] per_eff;
    logic [1:0]       abus_q, abus_d;
    logic [15:0]      dbus_q, dbus_d;
    logic             busy_q, busy_d;
    logic             fail_seen_q, fail_seen_d;
    logic [7:0]       srv_cnt_q, srv_cnt_d;

    // RSTOUT is part of the watchdog handshake but carries no action here.
    logic unused_rstout;
    assign unused_rstout = RSTOUT;

    // A zero period behaves as one WAIT cycle.
    assign per_eff = (per_q == '0) ? PER_ONE : per_q;

    // Next-state logic. WDFAIL overrides everything, which also drops the
    // data beat that would otherwise follow a key beat.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        per_d       = per_q;
        cnt_d       = cnt_q;
        srv_cnt_d   = srv_cnt_q;
        fail_seen_d = fail_seen_q | WDFAIL;

        // The service write completed on the data beat; the gap closes it.
        if (state_q == S_SRV_G) begin
            srv_cnt_d = srv_cnt_q + 8'd1;
        end

        if (WDFAIL) begin
            state_d = S_FAILED;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !STOP) begin
                        state_d = S_CFG_K;
                        cfg_d   = CFG;
                        per_d   = SRV_PERIOD;
                    end
                end
                S_CFG_K:  state_d = S_CFG_D;
                S_CFG_D:  state_d = S_CFG_G;
                S_CFG_G:  state_d = STOP ? S_IDLE : S_INIT_K;
                S_INIT_K: state_d = S_INIT_D;
                S_INIT_D: state_d = S_INIT_G;
                S_INIT_G: begin
                    if (STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = per_eff;
                    end
                end
                S_WAIT: begin
                    if (STOP) begin
                        state_d = S_IDLE;
                    end else if (cnt_q <= PER_ONE) begin
                        state_d = S_SRV_K;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - PER_ONE;
                    end
                end
                S_SRV_K:  state_d = S_SRV_D;
                S_SRV_D:  state_d = S_SRV_G;
                S_SRV_G: begin
                    if (STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = per_eff;
                    end
                end
                S_FAILED: state_d = S_FAILED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Bus outputs are decoded from the next state and registered, so the
    // bus always reflects the state occupied during that cycle.
    always_comb begin
        abus_d = ADDR_CFG;
        dbus_d = IDLE_WORD;
        busy_d = 1'b1;
        case (state_d)
            S_IDLE, S_FAILED: busy_d = 1'b0;
            S_CFG_K, S_INIT_K, S_SRV_K: dbus_d = KEY;
            S_CFG_D: dbus_d = {13'b0, cfg_d};
            S_INIT_D: begin
                abus_d = ADDR_INIT;
                dbus_d = DATA_ONE;
            end
            S_SRV_D: begin
                abus_d = ADDR_SRV;
                dbus_d = DATA_ONE;
            end
            default: begin
                abus_d = ADDR_CFG;
                dbus_d = IDLE_WORD;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            per_q       <= '0;
            cnt_q       <= '0;
            abus_q      <= 2'b00;
            dbus_q      <= IDLE_WORD;
            busy_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            srv_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            per_q       <= per_d;
            cnt_q       <= cnt_d;
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            busy_q      <= busy_d;
            fail_seen_q <= fail_seen_d;
            srv_cnt_q   <= srv_cnt_d;
        end
    end

    assign ABUS      = abus_q;
    assign DBUS      = dbus_q;
    assign BUSY      = busy_q;
    assign FAIL_SEEN = fail_seen_q;
    assign SRV_CNT   = srv_cnt_q;

endmodule

// File: tb/tb_wd_bus_master.sv
// tb_wd_bus_master: randomized scenarios against a beat-list reference
// model; expected bus cycles are queued and checked by a monitor.
module tb_wd_bus_master;

    localparam logic [15:0] KEY       = 16'hA5C3;
    localparam logic [15:0] IDLE_WORD = 16'h0000;
    localparam int K_I = 0, K_W = 1, K_K = 2, K_D = 3, K_G = 4;
    localparam int M_RUN = 0, M_IDLE = 1, M_FAIL = 2;
    localparam int NEVER = 1 << 30;

    logic        CLK = 0;
    logic        RST = 1;
    logic        START = 0, STOP = 0, WDFAIL = 0, RSTOUT = 0;
    logic [2:0]  CFG = '0;
    logic [15:0] SRV_PERIOD = '0;
    logic [1:0]  ABUS;
    logic [15:0] DBUS;
    logic        BUSY, FAIL_SEEN;
    logic [7:0]  SRV_CNT;

    typedef struct {
        int          cyc;
        logic [1:0]  a;
        logic [15:0] d;
        logic        busy;
        logic        fs;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   m_mode = M_IDLE;
    logic m_fs = 0;
    logic [7:0] m_cnt = 0;
    logic prev_key = 0;

    int          bk[$];
    logic [1:0]  ba[$];
    logic [15:0] bd[$];
    bit          bs[$];

    wd_bus_master dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
        .CFG(CFG), .SRV_PERIOD(SRV_PERIOD), .WDFAIL(WDFAIL),
        .RSTOUT(RSTOUT), .ABUS(ABUS), .DBUS(DBUS), .BUSY(BUSY),
        .FAIL_SEEN(FAIL_SEEN), .SRV_CNT(SRV_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [27:0] act,
                       input logic [27:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0d: got a=%b d=%h busy=%b fs=%b cnt=%0d want a=%b d=%h busy=%b fs=%b cnt=%0d",
                      nm, cyc, act[27:26], act[25:10], act[9], act[8], act[7:0],
                      req[27:26], req[25:10], req[9], req[8], req[7:0]);
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0d: got %b want %b", nm, cyc, act, req);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        logic [27:0] act;
        act = {ABUS, DBUS, BUSY, FAIL_SEEN, SRV_CNT};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk1("on_time", e.cyc == cyc, 1'b1);
            chk("bus_cycle", act, {e.a, e.d, e.busy, e.fs, e.cnt});
        end
        chk1("no_key_pair", !(prev_key && DBUS == KEY), 1'b1);
        chk1("no_abus_10", ABUS != 2'b10, 1'b1);
        prev_key = (DBUS == KEY);
    end

    task automatic push_beat(input int k, input logic [1:0] a,
                             input logic [15:0] d, input bit g);
        bk.push_back(k);
        ba.push_back(a);
        bd.push_back(d);
        bs.push_back(g);
    endtask

    task automatic push_tx(input logic [1:0] a, input logic [15:0] d,
                           input bit srv);
        push_beat(K_K, 2'b00, KEY, 0);
        push_beat(K_D, a, d, 0);
        push_beat(K_G, 2'b00, IDLE_WORD, srv);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1; START = 0; STOP = 0; WDFAIL = 0;
        #2;
        chk("reset", {ABUS, DBUS, BUSY, FAIL_SEEN, SRV_CNT},
            {2'b00, IDLE_WORD, 1'b0, 1'b0, 8'd0});
        #1;
        RST = 0;
        m_mode = M_IDLE; m_fs = 0; m_cnt = 0;
    endtask

    // Cycle 0 carries START; cycles 1..n are predicted. STOP is a level
    // rising at cycle s; WDFAIL is a one-cycle pulse at cycle f (or none).
    task automatic scen(input logic [2:0] cfg, input int p, input int s,
                        input int f, input int n);
        int pe, mode, base_cyc;
        logic fs;
        logic [7:0] cnt;
        exp_t e;
        bk.delete(); ba.delete(); bd.delete(); bs.delete();
        pe = (p == 0) ? 1 : p;
        push_beat(K_I, 2'b00, IDLE_WORD, 0);
        push_tx(2'b00, {13'b0, cfg}, 0);
        push_tx(2'b11, 16'h0001, 0);
        while (bk.size() <= n) begin
            repeat (pe) push_beat(K_W, 2'b00, IDLE_WORD, 0);
            push_tx(2'b01, 16'h0001, 1);
        end

        @(posedge CLK);
        #1;
        base_cyc = cyc;
        fs  = m_fs || (f == 0);
        cnt = m_cnt;
        if (m_mode == M_FAIL || f == 0) mode = M_FAIL;
        else if (m_mode == M_RUN) mode = M_RUN;
        else if (s == 0) mode = M_IDLE;
        else mode = M_RUN;
        for (int t = 1; t <= n; t++) begin
            e.cyc = base_cyc + t;
            if (mode == M_RUN) begin
                e.a = ba[t]; e.d = bd[t]; e.busy = 1'b1;
            end else begin
                e.a = 2'b00; e.d = IDLE_WORD; e.busy = 1'b0;
            end
            e.fs = fs;
            e.cnt = cnt;
            exp_q.push_back(e);
            if (mode == M_RUN && bs[t]) cnt = cnt + 8'd1;
            if (f == t) begin
                fs = 1'b1;
                mode = M_FAIL;
            end else if (mode == M_RUN && t >= s &&
                         (bk[t] == K_W || bk[t] == K_G)) begin
                mode = M_IDLE;
            end
        end
        m_mode = mode; m_fs = fs; m_cnt = cnt;

        for (int t = 0; t <= n; t++) begin
            if (t > 0) begin
                @(posedge CLK);
                #1;
            end
            START  = (t == 0) || (t < s && $urandom_range(0, 7) == 0);
            STOP   = (t >= s);
            WDFAIL = (t == f);
            RSTOUT = 1'($urandom);
            if (t == 0) begin
                CFG = cfg;
                SRV_PERIOD = 16'(p);
            end else begin
                CFG = 3'($urandom);
                SRV_PERIOD = 16'($urandom_range(0, 9));
            end
        end
    endtask

    initial begin
        int n, s, f;
        do_reset();
        scen(3'b101, 4, 28, -1, 32);
        scen(3'b010, 0, 20, -1, 26);
        scen(3'b001, 3, 10, -1, 16);
        scen(3'b101, 4, NEVER, 1, 8);
        scen(3'b011, 2, NEVER, -1, 8);
        do_reset();
        scen(3'b000, 5, 0, -1, 6);
        for (int i = 0; i < 25; i++) begin
            if (m_mode != M_IDLE || $urandom_range(0, 4) == 0) do_reset();
            n = $urandom_range(20, 80);
            s = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, n - 4);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
            scen(3'($urandom), $urandom_range(0, 6), s, f, n);
        end
        do_reset();
        scen(3'b110, 1, 1030, -1, 1035);
        @(posedge CLK);
        #1;
        STOP = 0; START = 0; WDFAIL = 0;
        repeat (5) @(posedge CLK);
        chk1("drain", exp_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
